// File: rtl/csr_file.sv
// csr_file: LoongArch CSR file beside WB; resolves exception commit, ERTN and masked CSR writes.
// Define CSR_TIMER_EN to build TID/TCFG/TVAL/TICLR and the ESTAT.IS[11] countdown timer.
module csr_file #(
  parameter int          TIMER_W  = 32,
  parameter int          NUM_SAVE = 4,
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_rd_num,
  output logic [31:0] csr_rd_value,
  input  logic        csr_we,
  input  logic [13:0] csr_wr_num,
  input  logic [31:0] csr_wr_mask,
  input  logic [31:0] csr_wr_value,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic        wb_badv_we,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_pc
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00c;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;
  localparam logic [12:0] LIE_MASK    = 13'h1bff;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] mask,
                                        input logic [31:0] val);
    return (mask & val) | (~mask & old_val);
  endfunction

  logic [1:0]  crmd_plv_q, crmd_plv_d;
  logic        crmd_ie_q, crmd_ie_d;
  logic [1:0]  prmd_pplv_q, prmd_pplv_d;
  logic        prmd_pie_q, prmd_pie_d;
  logic [12:0] ecfg_lie_q, ecfg_lie_d;
  logic [1:0]  is_sw_q, is_sw_d;
  logic [7:0]  is_hw_q, is_hw_d;
  logic        is_ipi_q, is_ipi_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [19:0] eentry_q, eentry_d;
  logic [31:0] save_q [NUM_SAVE];
  logic [31:0] save_d [NUM_SAVE];

  logic        csr_wr_en;
  logic        is_timer;
  logic [31:0] crmd_val, prmd_val, ecfg_val, estat_val, eentry_val, wr_new;

  // A CSR instruction write only lands when no exception or ERTN commits this cycle.
  assign csr_wr_en  = csr_we & ~wb_ex & ~ertn_flush;
  assign crmd_val   = {28'h0, 1'b1, crmd_ie_q, crmd_plv_q};
  assign prmd_val   = {29'h0, prmd_pie_q, prmd_pplv_q};
  assign ecfg_val   = {19'h0, ecfg_lie_q};
  assign estat_val  = {1'b0, esubcode_q, ecode_q, 3'b000,
                       is_ipi_q, is_timer, 1'b0, is_hw_q, is_sw_q};
  assign eentry_val = {eentry_q, 12'h000};

  assign has_int  = crmd_ie_q & |(estat_val[12:0] & ecfg_lie_q);
  assign ex_entry = eentry_val;
  assign ertn_pc  = era_q;

  always_comb begin
    crmd_plv_d  = crmd_plv_q;
    crmd_ie_d   = crmd_ie_q;
    prmd_pplv_d = prmd_pplv_q;
    prmd_pie_d  = prmd_pie_q;
    ecfg_lie_d  = ecfg_lie_q;
    is_sw_d     = is_sw_q;
    is_hw_d     = hw_int_in;
    is_ipi_d    = ipi_int_in;
    ecode_d     = ecode_q;
    esubcode_d  = esubcode_q;
    era_d       = era_q;
    badv_d      = badv_q;
    eentry_d    = eentry_q;
    wr_new      = '0;
    for (int i = 0; i < NUM_SAVE; i++) save_d[i] = save_q[i];

    if (wb_ex) begin
      prmd_pplv_d = crmd_plv_q;
      prmd_pie_d  = crmd_ie_q;
      crmd_plv_d  = 2'b00;
      crmd_ie_d   = 1'b0;
      ecode_d     = wb_ecode;
      esubcode_d  = wb_esubcode;
      era_d       = wb_pc;
      if (wb_badv_we) badv_d = wb_vaddr;
    end else if (ertn_flush) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end else if (csr_wr_en) begin
      case (csr_wr_num)
        ADDR_CRMD: begin
          wr_new     = merge(crmd_val, csr_wr_mask, csr_wr_value);
          crmd_plv_d = wr_new[1:0];
          crmd_ie_d  = wr_new[2];
        end
        ADDR_PRMD: begin
          wr_new      = merge(prmd_val, csr_wr_mask, csr_wr_value);
          prmd_pplv_d = wr_new[1:0];
          prmd_pie_d  = wr_new[2];
        end
        ADDR_ECFG: begin
          wr_new     = merge(ecfg_val, csr_wr_mask, csr_wr_value);
          ecfg_lie_d = wr_new[12:0] & LIE_MASK;
        end
        ADDR_ESTAT: begin
          wr_new  = merge(estat_val, csr_wr_mask, csr_wr_value);
          is_sw_d = wr_new[1:0];
        end
        ADDR_ERA: begin
          wr_new = merge(era_q, csr_wr_mask, csr_wr_value);
          era_d  = wr_new;
        end
        ADDR_BADV: begin
          wr_new = merge(badv_q, csr_wr_mask, csr_wr_value);
          badv_d = wr_new;
        end
        ADDR_EENTRY: begin
          wr_new   = merge(eentry_val, csr_wr_mask, csr_wr_value);
          eentry_d = wr_new[31:12];
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_SAVE; i++) begin
        if (csr_wr_num == ADDR_SAVE0 + 14'(i))
          save_d[i] = merge(save_q[i], csr_wr_mask, csr_wr_value);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_plv_q  <= '0;
      crmd_ie_q   <= 1'b0;
      prmd_pplv_q <= '0;
      prmd_pie_q  <= 1'b0;
      ecfg_lie_q  <= '0;
      is_sw_q     <= '0;
      is_hw_q     <= '0;
      is_ipi_q    <= 1'b0;
      ecode_q     <= '0;
      esubcode_q  <= '0;
      era_q       <= '0;
      badv_q      <= '0;
      eentry_q    <= '0;
      for (int i = 0; i < NUM_SAVE; i++) save_q[i] <= '0;
    end else begin
      crmd_plv_q  <= crmd_plv_d;
      crmd_ie_q   <= crmd_ie_d;
      prmd_pplv_q <= prmd_pplv_d;
      prmd_pie_q  <= prmd_pie_d;
      ecfg_lie_q  <= ecfg_lie_d;
      is_sw_q     <= is_sw_d;
      is_hw_q     <= is_hw_d;
      is_ipi_q    <= is_ipi_d;
      ecode_q     <= ecode_d;
      esubcode_q  <= esubcode_d;
      era_q       <= era_d;
      badv_q      <= badv_d;
      eentry_q    <= eentry_d;
      for (int i = 0; i < NUM_SAVE; i++) save_q[i] <= save_d[i];
    end
  end

`ifdef CSR_TIMER_EN
  localparam logic [TIMER_W-1:0] TVAL_ONE = TIMER_W'(1);

  logic [31:0]        tid_q, tid_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval_q, tval_d, tcfg_new;
  logic               armed_q, armed_d, is_timer_q, is_timer_d;
  logic               timer_expire, tcfg_wr, ticlr_wr;

  assign tcfg_wr      = csr_wr_en && (csr_wr_num == ADDR_TCFG);
  assign ticlr_wr     = csr_wr_en && (csr_wr_num == ADDR_TICLR) && csr_wr_mask[0] && csr_wr_value[0];
  assign timer_expire = armed_q & tcfg_q[0] & (tval_q == '0);
  assign tcfg_new     = (csr_wr_mask[TIMER_W-1:0] & csr_wr_value[TIMER_W-1:0]) |
                        (~csr_wr_mask[TIMER_W-1:0] & tcfg_q);
  assign is_timer     = is_timer_q;

  // One-shot expiry parks TVAL at all-ones and disarms until TCFG is rewritten;
  // a TCFG write overrides the counter, but an expiry in that cycle still raises IS[11].
  always_comb begin
    tid_d      = tid_q;
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    armed_d    = armed_q;
    is_timer_d = is_timer_q;

    if (armed_q && tcfg_q[0]) begin
      if (timer_expire) begin
        if (tcfg_q[1]) begin
          tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
        end else begin
          tval_d  = '1;
          armed_d = 1'b0;
        end
      end else begin
        tval_d = tval_q - TVAL_ONE;
      end
    end

    if (ticlr_wr)     is_timer_d = 1'b0;
    if (timer_expire) is_timer_d = 1'b1;

    if (csr_wr_en && (csr_wr_num == ADDR_TID))
      tid_d = merge(tid_q, csr_wr_mask, csr_wr_value);

    if (tcfg_wr) begin
      tcfg_d  = tcfg_new;
      tval_d  = {tcfg_new[TIMER_W-1:2], 2'b00};
      armed_d = tcfg_new[0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid_q      <= TID_INIT;
      tcfg_q     <= '0;
      tval_q     <= '0;
      armed_q    <= 1'b0;
      is_timer_q <= 1'b0;
    end else begin
      tid_q      <= tid_d;
      tcfg_q     <= tcfg_d;
      tval_q     <= tval_d;
      armed_q    <= armed_d;
      is_timer_q <= is_timer_d;
    end
  end
`else
  logic unused_timer_cfg;
  assign is_timer         = 1'b0;
  assign unused_timer_cfg = ^{TIMER_W, TID_INIT};
`endif

  // Reads see pre-update state; unmapped and out-of-range SAVE addresses fall through to 0.
  always_comb begin
    csr_rd_value = '0;
    if (csr_re) begin
      case (csr_rd_num)
        ADDR_CRMD:   csr_rd_value = crmd_val;
        ADDR_PRMD:   csr_rd_value = prmd_val;
        ADDR_ECFG:   csr_rd_value = ecfg_val;
        ADDR_ESTAT:  csr_rd_value = estat_val;
        ADDR_ERA:    csr_rd_value = era_q;
        ADDR_BADV:   csr_rd_value = badv_q;
        ADDR_EENTRY: csr_rd_value = eentry_val;
`ifdef CSR_TIMER_EN
        ADDR_TID:    csr_rd_value = tid_q;
        ADDR_TCFG:   csr_rd_value[TIMER_W-1:0] = tcfg_q;
        ADDR_TVAL:   csr_rd_value[TIMER_W-1:0] = tval_q;
`endif
        default: ;
      endcase
      for (int i = 0; i < NUM_SAVE; i++) begin
        if (csr_rd_num == ADDR_SAVE0 + 14'(i)) csr_rd_value = save_q[i];
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: register-field vector table plus interrupt, exception,
// timer (when CSR_TIMER_EN is defined) and asynchronous reset sequences.
module tb_csr_file;
  localparam int          TIMER_W  = 32;
  localparam int          NUM_SAVE = 4;
  localparam logic [31:0] TID_INIT = 32'h5a5a_0001;

  localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004;
  localparam logic [13:0] A_ESTAT = 14'h005, A_ERA = 14'h006, A_BADV = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00c, A_SAVE0 = 14'h030, A_TID = 14'h040;
  localparam logic [13:0] A_TCFG = 14'h041, A_TVAL = 14'h042, A_TICLR = 14'h044;

  logic        clk, resetn, csr_re, csr_we, wb_ex, wb_badv_we, ertn_flush, ipi_int_in;
  logic [13:0] csr_rd_num, csr_wr_num;
  logic [31:0] csr_rd_value, csr_wr_mask, csr_wr_value, wb_pc, wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [7:0]  hw_int_in;
  logic        has_int;
  logic [31:0] ex_entry, ertn_pc;

  csr_file #(.TIMER_W(TIMER_W), .NUM_SAVE(NUM_SAVE), .TID_INIT(TID_INIT)) dut (
    .clk(clk), .resetn(resetn),
    .csr_re(csr_re), .csr_rd_num(csr_rd_num), .csr_rd_value(csr_rd_value),
    .csr_we(csr_we), .csr_wr_num(csr_wr_num), .csr_wr_mask(csr_wr_mask),
    .csr_wr_value(csr_wr_value),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_badv_we(wb_badv_we), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .has_int(has_int), .ex_entry(ex_entry), .ertn_pc(ertn_pc)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_entry_t;

  typedef struct {
    string       name;
    logic [13:0] wr_num;
    logic [31:0] mask;
    logic [31:0] value;
    logic [13:0] rd_num;
    logic [31:0] exp;
  } vec_t;

  sb_entry_t sb_q[$];
  vec_t      vecs[$];
  int        checks = 0;
  int        errors = 0;

  task automatic expect_value(input string name, input logic [31:0] exp);
    sb_entry_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] act);
    sb_entry_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got %h with no expectation queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic read_csr(input logic [13:0] addr, output logic [31:0] val);
    csr_re     = 1'b1;
    csr_rd_num = addr;
    #1;
    val = csr_rd_value;
  endtask

  task automatic check_field(input string name, input logic [13:0] addr,
                             input logic [31:0] fmask, input logic [31:0] exp);
    logic [31:0] v;
    expect_value(name, exp);
    read_csr(addr, v);
    check_output(v & fmask);
  endtask

  task automatic check_read(input string name, input logic [13:0] addr, input logic [31:0] exp);
    check_field(name, addr, 32'hffff_ffff, exp);
  endtask

  task automatic check_sig(input string name, input logic [31:0] act, input logic [31:0] exp);
    expect_value(name, exp);
    check_output(act);
  endtask

  // One CSR write: driven just after a falling edge, lands on the next rising edge.
  task automatic apply_stimulus(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we       = 1'b1;
    csr_wr_num   = num;
    csr_wr_mask  = mask;
    csr_wr_value = val;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic wait_field(input logic [13:0] addr, input logic [31:0] fmask,
                            input logic [31:0] fval, input int limit, output int n);
    logic [31:0] v;
    n = 0;
    forever begin
      read_csr(addr, v);
      if ((v & fmask) == fval) break;
      if (n >= limit) break;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic add_vec(input string name, input logic [13:0] wr_num, input logic [31:0] mask,
                         input logic [31:0] value, input logic [13:0] rd_num, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.wr_num = wr_num; v.mask = mask; v.value = value;
    v.rd_num = rd_num; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    int n;

    resetn = 1'b0; csr_re = 1'b0; csr_rd_num = '0; csr_we = 1'b0; csr_wr_num = '0;
    csr_wr_mask = '0; csr_wr_value = '0; wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0;
    wb_pc = '0; wb_badv_we = 1'b0; wb_vaddr = '0; ertn_flush = 1'b0;
    hw_int_in = '0; ipi_int_in = 1'b0;

    add_vec("ecfg_lie_mask",   A_ECFG,      32'hffff_ffff, 32'h0000_1fff, A_ECFG,      32'h0000_1bff);
    add_vec("save3_masked",    A_SAVE0 + 3, 32'hffff_0000, 32'hdead_beef, A_SAVE0 + 3, 32'hdead_0000);
    add_vec("save0_full",      A_SAVE0,     32'hffff_ffff, 32'h1234_5678, A_SAVE0,     32'h1234_5678);
    add_vec("save_out_range",  A_SAVE0 + NUM_SAVE, 32'hffff_ffff, 32'hffff_ffff, A_SAVE0 + NUM_SAVE, 32'h0);
    add_vec("eentry_low_zero", A_EENTRY,    32'hffff_ffff, 32'h1c00_8fff, A_EENTRY,    32'h1c00_8000);
    add_vec("era_full",        A_ERA,       32'hffff_ffff, 32'h1c00_0004, A_ERA,       32'h1c00_0004);
    add_vec("estat_sw_only",   A_ESTAT,     32'hffff_ffff, 32'hffff_ffff, A_ESTAT,     32'h0000_0003);
    add_vec("prmd_fields",     A_PRMD,      32'hffff_ffff, 32'h0000_00ff, A_PRMD,      32'h0000_0007);
    add_vec("crmd_ie_only",    A_CRMD,      32'h0000_0004, 32'h0000_ffff, A_CRMD,      32'h0000_000c);
    add_vec("crmd_plv",        A_CRMD,      32'h0000_0003, 32'h0000_0001, A_CRMD,      32'h0000_000d);
    add_vec("badv_full",       A_BADV,      32'hffff_ffff, 32'habcd_0123, A_BADV,      32'habcd_0123);
    add_vec("unmapped_addr",   14'h002,     32'hffff_ffff, 32'hffff_ffff, 14'h002,     32'h0);
    add_vec("ecfg_partial",    A_ECFG,      32'h0000_000f, 32'h0000_0000, A_ECFG,      32'h0000_1bf0);

    // Reset values, observed while reset is still asserted.
    #20;
    check_sig("rd_disabled", csr_rd_value, 32'h0);
    check_read("reset_crmd", A_CRMD, 32'h8);
    check_read("reset_estat", A_ESTAT, 32'h0);
    check_sig("reset_has_int", {31'b0, has_int}, 32'h0);
    check_sig("reset_ex_entry", ex_entry, 32'h0);
    check_sig("reset_ertn_pc", ertn_pc, 32'h0);
`ifdef CSR_TIMER_EN
    check_read("reset_tid", A_TID, TID_INIT);
`else
    check_read("reset_tid_absent", A_TID, 32'h0);
`endif
    csr_re = 1'b0;
    check_sig("rd_disabled_crmd", csr_rd_value, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].wr_num, vecs[i].mask, vecs[i].value);
      check_read(vecs[i].name, vecs[i].rd_num, vecs[i].exp);
    end

    // Interrupt sampling: CRMD.IE=1, ECFG.LIE=0x1bf0, IS[1:0]=3 from the table.
    check_sig("has_int_masked", {31'b0, has_int}, 32'h0);
    hw_int_in = 8'h04;
    check_sig("has_int_before_edge", {31'b0, has_int}, 32'h0);
    @(negedge clk);
    check_sig("has_int_hw", {31'b0, has_int}, 32'h1);
    check_read("estat_hw", A_ESTAT, 32'h0000_0013);
    hw_int_in  = 8'h00;
    ipi_int_in = 1'b1;
    @(negedge clk);
    check_read("estat_ipi", A_ESTAT, 32'h0000_1003);
    check_sig("has_int_ipi", {31'b0, has_int}, 32'h1);
    apply_stimulus(A_CRMD, 32'h4, 32'h0);
    check_sig("has_int_ie_off", {31'b0, has_int}, 32'h0);
    ipi_int_in = 1'b0;

    // Exception commit beats a same-cycle ERTN and CSR write.
    apply_stimulus(A_ESTAT, 32'h3, 32'h0);
    apply_stimulus(A_PRMD, 32'hffff_ffff, 32'h0);
    apply_stimulus(A_CRMD, 32'h7, 32'h7);
    check_read("crmd_pre_ex", A_CRMD, 32'hf);
    wb_ex = 1'b1; wb_ecode = 6'h0b; wb_esubcode = 9'h001; wb_pc = 32'h1c00_0100;
    wb_badv_we = 1'b1; wb_vaddr = 32'hbadc_0de0; ertn_flush = 1'b1;
    csr_we = 1'b1; csr_wr_num = A_ERA; csr_wr_mask = 32'hffff_ffff; csr_wr_value = 32'h1111_1111;
    @(negedge clk);
    wb_ex = 1'b0; wb_badv_we = 1'b0; ertn_flush = 1'b0; csr_we = 1'b0;
    check_read("ex_crmd", A_CRMD, 32'h8);
    check_read("ex_prmd", A_PRMD, 32'h7);
    check_read("ex_estat", A_ESTAT, 32'h004b_0000);
    check_read("ex_era", A_ERA, 32'h1c00_0100);
    check_sig("ex_ertn_pc", ertn_pc, 32'h1c00_0100);
    check_read("ex_badv", A_BADV, 32'hbadc_0de0);

    // ERTN beats a same-cycle CSR write to CRMD.
    ertn_flush = 1'b1;
    csr_we = 1'b1; csr_wr_num = A_CRMD; csr_wr_mask = 32'h7; csr_wr_value = 32'h0;
    @(negedge clk);
    ertn_flush = 1'b0; csr_we = 1'b0;
    check_read("ertn_crmd", A_CRMD, 32'hf);

    wb_ex = 1'b1; wb_ecode = 6'h3f; wb_esubcode = 9'h000; wb_pc = 32'h1c00_0200;
    wb_badv_we = 1'b0; wb_vaddr = 32'h1234_5678;
    @(negedge clk);
    wb_ex = 1'b0;
    check_read("ex2_badv_kept", A_BADV, 32'hbadc_0de0);
    check_read("ex2_estat", A_ESTAT, 32'h003f_0000);
    check_read("ex2_era", A_ERA, 32'h1c00_0200);
    check_sig("ex_entry_out", ex_entry, 32'h1c00_8000);

`ifdef CSR_TIMER_EN
    // One-shot: InitVal 4 -> TVAL 0x10 counting down, then parked at all-ones.
    apply_stimulus(A_TCFG, 32'hffff_ffff, 32'h0000_0011);
    for (int k = 16; k >= 0; k--) begin
      check_read("tval_count", A_TVAL, 32'(k));
      @(negedge clk);
    end
    check_field("oneshot_is11", A_ESTAT, 32'h800, 32'h800);
    check_read("oneshot_tval_park", A_TVAL, 32'hffff_ffff);
    repeat (3) @(negedge clk);
    check_read("oneshot_tval_hold", A_TVAL, 32'hffff_ffff);
    check_read("tcfg_readback", A_TCFG, 32'h0000_0011);
    apply_stimulus(A_TICLR, 32'h1, 32'h1);
    check_field("ticlr_clears", A_ESTAT, 32'h800, 32'h0);
    check_read("ticlr_reads0", A_TICLR, 32'h0);

    // Periodic: InitVal 2 -> expiry every 9 cycles.
    apply_stimulus(A_CRMD, 32'h4, 32'h4);
    apply_stimulus(A_TCFG, 32'hffff_ffff, 32'h0000_000b);
    wait_field(A_ESTAT, 32'h800, 32'h800, 40, n);
    check_sig("periodic_first_set", 32'(n), 32'd9);
    check_sig("has_int_timer", {31'b0, has_int}, 32'h1);
    apply_stimulus(A_TICLR, 32'h1, 32'h1);
    wait_field(A_ESTAT, 32'h800, 32'h800, 40, n);
    check_sig("periodic_second_set", 32'(n), 32'd8);
    apply_stimulus(A_TICLR, 32'h1, 32'h1);
    wait_field(A_TVAL, 32'hffff_ffff, 32'h0, 40, n);
    check_sig("periodic_tval_zero", 32'(n), 32'd7);
    apply_stimulus(A_TICLR, 32'h1, 32'h1);
    check_field("clear_vs_expire", A_ESTAT, 32'h800, 32'h800);

    // TCFG write in the expiry cycle: new TVAL, IS[11] still set.
    apply_stimulus(A_TICLR, 32'h1, 32'h1);
    wait_field(A_TVAL, 32'hffff_ffff, 32'h0, 40, n);
    check_sig("periodic_tval_zero2", 32'(n), 32'd7);
    apply_stimulus(A_TCFG, 32'hffff_ffff, 32'h0000_0021);
    check_read("tcfg_vs_expire_tval", A_TVAL, 32'h0000_0020);
    check_field("tcfg_vs_expire_is11", A_ESTAT, 32'h800, 32'h800);
    repeat (5) @(negedge clk);
`else
    apply_stimulus(A_TCFG, 32'hffff_ffff, 32'h0000_0011);
    apply_stimulus(A_TID, 32'hffff_ffff, 32'hcafe_f00d);
    check_read("tcfg_absent", A_TCFG, 32'h0);
    check_read("tid_absent", A_TID, 32'h0);
    repeat (20) @(negedge clk);
    check_read("tval_absent", A_TVAL, 32'h0);
    check_field("is11_absent", A_ESTAT, 32'h800, 32'h0);
`endif

    // Asynchronous reset mid-cycle and mid-count.
    #20;
    resetn = 1'b0;
    #1;
    check_read("arst_crmd", A_CRMD, 32'h8);
    check_read("arst_prmd", A_PRMD, 32'h0);
    check_read("arst_ecfg", A_ECFG, 32'h0);
    check_read("arst_estat", A_ESTAT, 32'h0);
    check_read("arst_save0", A_SAVE0, 32'h0);
    check_sig("arst_has_int", {31'b0, has_int}, 32'h0);
    check_sig("arst_ertn_pc", ertn_pc, 32'h0);
    check_sig("arst_ex_entry", ex_entry, 32'h0);
`ifdef CSR_TIMER_EN
    check_read("arst_tcfg", A_TCFG, 32'h0);
    check_read("arst_tval", A_TVAL, 32'h0);
    check_read("arst_tid", A_TID, TID_INIT);
`endif
    @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    check_field("post_reset_no_expiry", A_ESTAT, 32'h800, 32'h0);
`ifdef CSR_TIMER_EN
    check_read("post_reset_tval", A_TVAL, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
